// File: rtl/weight_update_ctrl.sv
// Training sequencer for the 2-layer backprop network.
// Broadcasts select_initial / select_update to every weight register and
// handshakes with the forward-pass and backprop datapaths, stepping through
// samples and epochs until convergence or the epoch limit.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start
// S_INIT      | select_initial pulse, weights load initial values
// S_FWD_START | fwd_start pulse for the current sample
// S_FWD_WAIT  | waiting for fwd_done, err checked against threshold
// S_BP_START  | bp_start pulse
// S_BP_WAIT   | waiting for bp_done (no timeout)
// S_UPD       | select_update pulse, weights add their deltas
// S_NEXT      | advance sample / epoch, decide whether training is over
// S_DONE      | training finished, counters hold final values
module weight_update_ctrl #(
  parameter int                 N_SAMPLES = 4,
  parameter int                 N_EPOCHS  = 1000,
  parameter logic signed [15:0] ERR_TH    = 16'sd41
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               fwd_done,
  input  logic               bp_done,
  input  logic signed [15:0] err,
  output logic               select_initial,
  output logic               select_update,
  output logic               fwd_start,
  output logic               bp_start,
  output logic [7:0]         sample_idx,
  output logic [15:0]        epoch_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_FWD_START,
    S_FWD_WAIT,
    S_BP_START,
    S_BP_WAIT,
    S_UPD,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [7:0]         LAST_SAMPLE = 8'(N_SAMPLES - 1);
  localparam logic [15:0]        EPOCH_MAX   = 16'(N_EPOCHS);
  localparam logic signed [16:0] TH_EXT      = {ERR_TH[15], ERR_TH};

  state_t             state;
  state_t             next_state;
  logic               conv;
  logic signed [16:0] err_ext;
  logic signed [16:0] err_mag;
  logic               err_big;
  logic               last_sample;
  logic [15:0]        epoch_inc;
  logic               finish;
  logic               abort_now;

  // Magnitude of err in 17 bits so that -32768 maps to +32768 (above threshold).
  always_comb begin
    err_ext = {err[15], err};
    err_mag = err_ext[16] ? -err_ext : err_ext;
    err_big = (err_mag >= TH_EXT);
  end

  // End-of-epoch decision terms; the epoch counter saturates at the limit.
  always_comb begin
    last_sample = (sample_idx == LAST_SAMPLE);
    epoch_inc   = (epoch_cnt == EPOCH_MAX) ? epoch_cnt : epoch_cnt + 16'd1;
    finish      = conv || (epoch_inc == EPOCH_MAX);
    abort_now   = abort && (state != S_IDLE);
  end

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    next_state = state;
    if (abort_now) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start) next_state = S_INIT;
        S_INIT:      next_state = S_FWD_START;
        S_FWD_START: next_state = S_FWD_WAIT;
        S_FWD_WAIT:  if (fwd_done) next_state = S_BP_START;
        S_BP_START:  next_state = S_BP_WAIT;
        S_BP_WAIT:   if (bp_done) next_state = S_UPD;
        S_UPD:       next_state = S_NEXT;
        S_NEXT: begin
          if (last_sample && finish) next_state = S_DONE;
          else                       next_state = S_FWD_START;
        end
        S_DONE:      if (start) next_state = S_INIT;
        default:     next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Moore outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      select_initial <= 1'b0;
      select_update  <= 1'b0;
      fwd_start      <= 1'b0;
      bp_start       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      select_initial <= (next_state == S_INIT);
      select_update  <= (next_state == S_UPD);
      fwd_start      <= (next_state == S_FWD_START);
      bp_start       <= (next_state == S_BP_START);
      busy           <= (next_state != S_IDLE) && (next_state != S_DONE);
      done           <= (next_state == S_DONE);
    end
  end

  // Sample/epoch counters and convergence flag; cleared on entry to INIT so they read 0 during the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_idx <= 8'd0;
      epoch_cnt  <= 16'd0;
      conv       <= 1'b1;
    end else if (!abort_now) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sample_idx <= 8'd0;
            epoch_cnt  <= 16'd0;
            conv       <= 1'b1;
          end
        end
        S_FWD_WAIT: begin
          if (fwd_done && err_big) conv <= 1'b0;
        end
        S_NEXT: begin
          if (!last_sample) begin
            sample_idx <= sample_idx + 8'd1;
          end else begin
            epoch_cnt <= epoch_inc;
            if (!finish) begin
              sample_idx <= 8'd0;
              conv       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
